// File: rtl/arbitro_mux4.sv
// ============================================================================
// Module   : arbitro_mux4
// Brief    : 4-requester round-robin arbiter with hold limit, driving a shared 4x1 4-bit mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_mux4 #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] ent0,
  input  logic [3:0] ent1,
  input  logic [3:0] ent2,
  input  logic [3:0] ent3,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] out,
  output logic       vld
);

  localparam logic [3:0] c_hold_max = 4'(HOLD_MAX);

  typedef enum logic [0:0] {
    OCIOSO  = 1'b0,
    OCUPADO = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [3:0] r_out;
  logic       r_vld;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;

  state_t     w_state_nx;
  logic [3:0] w_gnt_nx;
  logic [1:0] w_sel_nx;
  logic [3:0] w_out_nx;
  logic       w_vld_nx;
  logic [1:0] w_ptr_nx;
  logic [3:0] w_cnt_nx;

  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_grant;
  logic       w_own_req;
  logic       w_others;
  logic [3:0] w_mux;

  // Round-robin search starting at r_ptr; the current owner sits last in the order.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_mux = ent0;
    case (r_sel)
      2'd0:    w_mux = ent0;
      2'd1:    w_mux = ent1;
      2'd2:    w_mux = ent2;
      default: w_mux = ent3;
    endcase
  end

  assign w_own_req = req[r_sel];
  assign w_others  = |(req & ~r_gnt);

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_sel_nx   = r_sel;
    w_out_nx   = r_out;
    w_vld_nx   = 1'b0;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_grant    = 1'b0;

    case (r_state)
      OCIOSO: begin
        if (w_found) begin
          w_grant = 1'b1;
        end else begin
          w_gnt_nx = 4'b0000;
        end
      end
      default: begin
        if (w_own_req) begin
          if ((r_cnt < c_hold_max) || !w_others) begin
            w_out_nx = w_mux;
            w_vld_nx = 1'b1;
            if (r_cnt < c_hold_max) begin
              w_cnt_nx = r_cnt + 4'd1;
            end
          end else begin
            w_grant = 1'b1;
          end
        end else if (w_found) begin
          w_grant = 1'b1;
        end else begin
          w_gnt_nx   = 4'b0000;
          w_state_nx = OCIOSO;
        end
      end
    endcase

    if (w_grant) begin
      w_state_nx = OCUPADO;
      w_gnt_nx   = 4'b0001 << w_win;
      w_sel_nx   = w_win;
      w_ptr_nx   = w_win + 2'd1;
      w_cnt_nx   = 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OCIOSO;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_out   <= 4'b0000;
      r_vld   <= 1'b0;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_sel   <= w_sel_nx;
      r_out   <= w_out_nx;
      r_vld   <= w_vld_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign gnt = r_gnt;
  assign sel = r_sel;
  assign out = r_out;
  assign vld = r_vld;

endmodule

`default_nettype wire

// File: tb/tb_arbitro_mux4.sv
// ============================================================================
// Module   : tb_arbitro_mux4
// Brief    : Directed scoreboard bench for arbitro_mux4 (HOLD_MAX = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_mux4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ent0, ent1, ent2, ent3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] out;
  logic       vld;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {sel, out} for each cycle the DUT presents vld.
  logic [5:0] exp_q[$];

  arbitro_mux4 #(.HOLD_MAX(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .ent0 (ent0),
    .ent1 (ent1),
    .ent2 (ent2),
    .ent3 (ent3),
    .gnt  (gnt),
    .sel  (sel),
    .out  (out),
    .vld  (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [3:0] d);
    exp_q.push_back({s, d});
  endtask

  // Monitor: every data cycle must match the next scoreboard entry; gnt stays at most one-hot.
  always @(negedge clk) begin
    logic [5:0] e;
    n_checks++;
    if ($countones(gnt) > 1) begin
      n_errors++;
      $display("FAIL onehot: gnt=%b", gnt);
    end
    if (vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_vld: sel=%0d out=%h, nothing expected", sel, out);
      end else begin
        e = exp_q.pop_front();
        if ({sel, out} !== e) begin
          n_errors++;
          $display("FAIL data: sel/out=%0d/%h expected %0d/%h at %0t",
                   sel, out, e[5:4], e[3:0], $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = 4'b0;
    ent0 = 4'h0; ent1 = 4'h0; ent2 = 4'h0; ent3 = 4'h0;
    step(); step();
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_sel", 8'(sel), 8'h0);
    chk("rst_out", 8'(out), 8'h0);
    chk("rst_vld", 8'(vld), 8'h0);
    rst = 1'b0;

    // Single requester held past the hold limit, data changing mid-ownership.
    ent1 = 4'h5; req = 4'b0010;
    step();
    chk("single_gnt", 8'(gnt), 8'h02);
    chk("single_sel", 8'(sel), 8'h1);
    chk("single_vld0", 8'(vld), 8'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) ent1 = 4'h6;
      push(2'd1, (i < 3) ? 4'h5 : 4'h6);
      step();
      chk("single_hold_gnt", 8'(gnt), 8'h02);
      chk("single_hold_vld", 8'(vld), 8'h1);
    end
    ent1 = 4'h7; req = 4'b0000;
    step();
    chk("single_rel_gnt", 8'(gnt), 8'h0);
    chk("single_rel_sel", 8'(sel), 8'h1);
    chk("single_rel_vld", 8'(vld), 8'h0);
    chk("single_rel_out", 8'(out), 8'h6);

    // Forced rotation after HOLD_MAX grant cycles.
    ent0 = 4'h1; ent3 = 4'h3; req = 4'b0001;
    step();
    chk("rot_gnt_c1", 8'(gnt), 8'h01);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      push(2'd0, 4'h1);
      step();
      chk("rot_gnt_hold", 8'(gnt), 8'h01);
    end
    step();
    chk("rot_gnt3", 8'(gnt), 8'h08);
    chk("rot_sel3", 8'(sel), 8'h3);
    chk("rot_vld0", 8'(vld), 8'h0);
    chk("rot_out_hold", 8'(out), 8'h1);
    push(2'd3, 4'h3);
    step();
    chk("rot_own3_vld", 8'(vld), 8'h1);
    req = 4'b0000;
    step();
    chk("rot_rel_gnt", 8'(gnt), 8'h0);

    // Reset in the middle of a grant.
    ent2 = 4'hC; req = 4'b0100;
    step();
    chk("mid_gnt", 8'(gnt), 8'h04);
    push(2'd2, 4'hC);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", 8'(gnt), 8'h0);
    chk("mid_rst_sel", 8'(sel), 8'h0);
    chk("mid_rst_out", 8'(out), 8'h0);
    chk("mid_rst_vld", 8'(vld), 8'h0);
    rst = 1'b0;
    step();
    chk("mid_regrant", 8'(gnt), 8'h04);
    chk("mid_regrant_sel", 8'(sel), 8'h2);
    req = 4'b0000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Round-robin with back-to-back handoffs; first winner proves ptr restarted at 0.
    ent0 = 4'h8; ent1 = 4'h9; ent2 = 4'hA; ent3 = 4'hB; req = 4'b1111;
    step();
    chk("rr_first", 8'(gnt), 8'h01);
    for (int k = 0; k < 4; k++) begin
      push(2'(k), 4'(8 + k));
      step();
      chk("rr_data_vld", 8'(vld), 8'h1);
      req = 4'hF ^ (4'b0001 << k);
      step();
      chk("rr_next_gnt", 8'(gnt), 8'(4'b0001 << ((k + 1) % 4)));
      chk("rr_next_vld", 8'(vld), 8'h0);
      chk("rr_out_hold", 8'(out), 8'(8 + k));
    end
    req = 4'b0000;
    step();
    chk("rr_idle_gnt", 8'(gnt), 8'h0);
    chk("rr_idle_sel", 8'(sel), 8'h0);

    // Wrap from ptr=3 and withdrawal before grant.
    req = 4'b0100;
    step();
    chk("wrap_pre_gnt", 8'(gnt), 8'h04);
    req = 4'b0000;
    step();
    req = 4'b1001;
    step();
    chk("wrap_gnt3", 8'(gnt), 8'h08);
    chk("wrap_sel3", 8'(sel), 8'h3);
    req = 4'b1000;
    push(2'd3, 4'hB);
    step();
    chk("wrap_data_vld", 8'(vld), 8'h1);
    req = 4'b0000;
    step();
    chk("wrap_rel_gnt", 8'(gnt), 8'h0);
    chk("wrap_rel_sel", 8'(sel), 8'h3);
    step();
    chk("wrap_idle_gnt", 8'(gnt), 8'h0);
    chk("wrap_idle_vld", 8'(vld), 8'h0);

    step();
    chk("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
